muldiv_issue_ctrl: RTL and testbench

- Core-side initiator for the M-extension MULDIV unit.
- Accepts one decoded M instruction (funct3, rs1, rs2, rd) through a valid/ready handshake.
- Drives the MULDIV operand, funct3 and start inputs, and polls its busy flag.
- Captures the 32-bit result and presents it on a writeback channel with backpressure. It also stalls the pipeline while an operation is outstanding.

---
 rtl/muldiv_issue_ctrl.sv | 107 ++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Core-side issue/writeback controller for the M-extension MULDIV unit.
// Issues one op at a time, polls busy with a timeout, and holds the result until accepted.
module muldiv_issue_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rstLow,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [31:0] md_rs1,
    output logic [31:0] md_rs2,
    output logic [2:0]  md_funct3,
    output logic        md_start,
    input  logic        md_busy,
    input  logic [31:0] md_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Gated by reset so every output reads 0 while rstLow is held low.
    assign req_ready = rstLow && (state == IDLE);
    assign stall     = (state != IDLE);

    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            md_rs1    <= '0;
            md_rs2    <= '0;
            md_funct3 <= '0;
            md_start  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_valid  <= 1'b0;
            wb_err    <= 1'b0;
        end else begin
            md_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        md_rs1    <= req_rs1;
                        md_rs2    <= req_rs2;
                        md_funct3 <= req_funct3;
                        wb_rd     <= req_rd;
                        md_start  <= req_funct3[2];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (md_funct3[2]) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        wb_data  <= md_result;
                        wb_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                WAIT: begin
                    if (!md_busy) begin
                        wb_data  <= md_result;
                        wb_valid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) begin
                            wb_err   <= 1'b1;
                            wb_data  <= '0;
                            wb_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_err   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural MULDIV stub.
// Vector table covers MUL/DIV classes; hand sequences cover timeout and reset.
module tb_muldiv_issue_ctrl;

    localparam int MAX_WAIT = 64;
    localparam int LIMIT    = 200;

    logic        clk = 1'b0;
    logic        rstLow = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] md_rs1, md_rs2;
    logic [2:0]  md_funct3;
    logic        md_start;
    logic        md_busy;
    logic [31:0] md_result;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_issue_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(7)) dut (
        .clk(clk), .rstLow(rstLow),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_rd(req_rd),
        .md_rs1(md_rs1), .md_rs2(md_rs2),
        .md_funct3(md_funct3), .md_start(md_start),
        .md_busy(md_busy), .md_result(md_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .stall(stall)
    );

    always #5 clk = ~clk;

    // ---------------- MULDIV stub ----------------
    int          stub_len = 1;
    logic        stub_stuck = 1'b0;
    int          busy_left;
    logic        prev_ok;
    logic [2:0]  prev_f3;
    logic [31:0] prev_a, prev_b;
    int          start_cnt;

    function automatic logic [31:0] md_calc(
        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        logic ovf;
        ea  = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(
        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic fused;
        fused = prev_ok && prev_a == a && prev_b == b &&
                prev_f3[2:1] == 2'b10 && f3[2:1] == 2'b11 &&
                prev_f3[0] == f3[0];
        return (b == 0) || fused ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    always @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            md_busy   <= 1'b0;
            busy_left <= 0;
            prev_ok   <= 1'b0;
            prev_f3   <= '0;
            prev_a    <= '0;
            prev_b    <= '0;
        end else if (md_start) begin
            prev_ok <= 1'b1;
            prev_f3 <= md_funct3;
            prev_a  <= md_rs1;
            prev_b  <= md_rs2;
            if (is_special(md_funct3, md_rs1, md_rs2)) begin
                md_busy <= 1'b0;
            end else begin
                md_busy   <= 1'b1;
                busy_left <= stub_len - 1;
            end
        end else if (md_busy && !stub_stuck) begin
            if (busy_left == 0) md_busy <= 1'b0;
            else busy_left <= busy_left - 1;
        end
    end

    assign md_result = md_busy ? 32'hDEAD_BEEF
                               : md_calc(md_funct3, md_rs1, md_rs2);

    always @(posedge clk or negedge rstLow) begin
        if (!rstLow) start_cnt <= 0;
        else if (md_start) start_cnt <= start_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          busy;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          starts;
    } vec_t;

    vec_t vt[8];

    task automatic run_op(input string tag, input vec_t v);
        int lat, stall_n, s0;
        @(negedge clk);
        stub_len   = v.busy;
        req_funct3 = v.f3;
        req_rs1    = v.a;
        req_rs2    = v.b;
        req_rd     = v.rd;
        req_valid  = 1'b1;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        s0 = start_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat     = 1;
        stall_n = stall ? 1 : 0;
        while (!wb_valid && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
            if (stall) stall_n++;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " wb_data"}, wb_data, v.data);
        check({tag, " wb_err"}, 32'(wb_err), 32'(v.err));
        check({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        check({tag, " starts"}, 32'(start_cnt - s0), 32'(v.starts));
        check({tag, " stall_cycles"}, 32'(stall_n), 32'(v.lat));
        if (wb_ready) begin
            @(posedge clk);
            #1;
            check({tag, " idle_after"}, {30'b0, wb_valid, stall}, 32'd0);
        end
    endtask

    initial begin
        vt[0] = '{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1,
                  32'hFFFF_FFEB, 1'b0, 2, 0};
        vt[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1,
                  32'hFFFF_FFFE, 1'b0, 2, 0};
        vt[2] = '{3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 5,
                  32'hFFFF_FFFA, 1'b0, 8, 1};
        vt[3] = '{3'd6, 32'hFFFF_FFEC, 32'd3, 5'd8, 5,
                  32'hFFFF_FFFE, 1'b0, 3, 1};
        vt[4] = '{3'd5, 32'h0000_1234, 32'd0, 5'd9, 4,
                  32'hFFFF_FFFF, 1'b0, 3, 1};
        vt[5] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 1,
                  32'h4000_0000, 1'b0, 2, 0};
        vt[6] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 4,
                  32'h8000_0000, 1'b0, 3, 1};
        vt[7] = '{3'd7, 32'd100, 32'd7, 5'd12, 3,
                  32'd2, 1'b0, 6, 1};

        #1 rstLow = 1'b0;
        #3;
        check("reset outs", {md_rs1 | md_rs2 | wb_data},
              32'd0);
        check("reset ctrl", {22'b0, md_funct3, wb_rd, md_start, wb_valid},
              32'd0);
        check("reset flags", {29'b0, wb_err, stall, req_ready}, 32'd0);
        @(negedge clk);
        rstLow = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset ready", {30'b0, req_ready, stall}, 32'b10);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i]);
        end

        // Divider stuck busy: timeout, then backpressure hold.
        stub_stuck = 1'b1;
        wb_ready   = 1'b0;
        run_op("timeout", '{3'd5, 32'd100, 32'd7, 5'd13, 1,
                            32'd0, 1'b1, 2 + MAX_WAIT, 1});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d valid/err/ready", c),
                  {29'b0, wb_valid, wb_err, req_ready}, 32'b110);
            check($sformatf("hold%0d data", c), wb_data, 32'd0);
            check($sformatf("hold%0d rd", c), 32'(wb_rd), 32'd13);
        end
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        check("timeout release", {29'b0, wb_valid, wb_err, req_ready},
              32'b001);
        stub_stuck = 1'b0;

        // Reset while a real divide is in WAIT.
        @(negedge clk);
        stub_len   = 20;
        req_funct3 = 3'd4;
        req_rs1    = 32'd1000;
        req_rs2    = 32'd9;
        req_rd     = 5'd14;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid busy", 32'(md_busy), 32'd1);
        rstLow = 1'b0;
        #1;
        check("midrst ops", md_rs1 | md_rs2 | wb_data, 32'd0);
        check("midrst ctrl",
              {20'b0, md_funct3, wb_rd, md_start, wb_valid, wb_err,
               stall},
              32'd0);
        check("midrst ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rstLow = 1'b1;
        @(posedge clk);
        #1;
        check("midrst release", {30'b0, req_ready, stall}, 32'b10);
        run_op("mul2x3", '{3'd0, 32'd2, 32'd3, 5'd15, 1,
                           32'd6, 1'b0, 2, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
